// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM row write/invalidate decoder.
package tcam_pkg;

    // Geometry of the TCAM row array.
    localparam int TCAM_ROWS = 64;
    localparam int TCAM_AW   = 6;

    // Strobe-hold counter width; covers WR_CYCLES up to 15.
    localparam int WR_CNT_W  = 4;

    // Request opcodes.
    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_INV     = 2'b01,
        OP_INV_ALL = 2'b10,
        OP_RSVD    = 2'b11
    } op_e;

    // Control FSM states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STROBE = 2'b01,
        ST_SWEEP  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/decoder_6x64.sv
// Combinational row index to one-hot decoder.
module decoder_6x64
    import tcam_pkg::*;
#(
    parameter int AW   = TCAM_AW,
    parameter int ROWS = TCAM_ROWS
) (
    input  logic [AW-1:0]   i_idx,
    output logic [ROWS-1:0] o_onehot
);

    // One comparator per row output.
    for (genvar g = 0; g < ROWS; g++) begin : g_row
        assign o_onehot[g] = (i_idx == AW'(g));
    end

endmodule

// File: rtl/tcam_row_write_decoder.sv
// Row write / invalidate strobe generator for a 64-row TCAM, with the
// row valid map used to mask match lines ahead of the priority encoder.
module tcam_row_write_decoder
    import tcam_pkg::*;
#(
    parameter int ROWS      = TCAM_ROWS,
    parameter int AW        = TCAM_AW,
    parameter int WR_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [AW-1:0]   req_addr,
    output logic [ROWS-1:0] row_we,
    output logic [ROWS-1:0] row_inv,
    output logic [ROWS-1:0] valid_map,
    output logic            done,
    output logic            err
);

    state_e                r_state;
    op_e                   r_op;
    logic [AW-1:0]         r_idx;      // target row in STROBE, sweep row in SWEEP
    logic [WR_CNT_W-1:0]   r_cnt;
    logic [ROWS-1:0]       r_row_we;
    logic [ROWS-1:0]       r_row_inv;
    logic [ROWS-1:0]       r_valid_map;
    logic                  r_done;
    logic                  r_err;

    op_e                   w_req_op;
    logic                  w_accept;
    logic [AW-1:0]         w_dec_idx;
    logic [ROWS-1:0]       w_onehot;

    assign w_req_op  = op_e'(req_op);
    assign req_ready = (r_state == ST_IDLE);
    assign w_accept  = req_valid && req_ready;

    assign row_we    = r_row_we;
    assign row_inv   = r_row_inv;
    assign valid_map = r_valid_map;
    assign done      = r_done;
    assign err       = r_err;

    // Pick the row the shared decoder looks at: the incoming address (or the
    // top row for a sweep) while idle, the next-lower row while sweeping, and
    // the captured target row otherwise.
    always_comb begin
        w_dec_idx = r_idx;
        case (r_state)
            ST_IDLE:  w_dec_idx = (w_req_op == OP_INV_ALL) ? AW'(ROWS - 1) : req_addr;
            ST_SWEEP: w_dec_idx = r_idx - AW'(1);
            default:  w_dec_idx = r_idx;
        endcase
    end

    decoder_6x64 #(
        .AW   (AW),
        .ROWS (ROWS)
    ) u_dec (
        .i_idx    (w_dec_idx),
        .o_onehot (w_onehot)
    );

    // Control FSM; strobes and the valid map are all registered so the row
    // array sees clean, glitch-free enables.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_WRITE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_row_we    <= '0;
            r_row_inv   <= '0;
            r_valid_map <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_req_op;
                        r_idx <= w_dec_idx;
                        r_cnt <= WR_CNT_W'(WR_CYCLES - 1);
                        case (w_req_op)
                            OP_WRITE: begin
                                r_row_we <= w_onehot;
                                r_state  <= ST_STROBE;
                            end
                            OP_INV: begin
                                r_row_inv <= w_onehot;
                                r_state   <= ST_STROBE;
                            end
                            OP_INV_ALL: begin
                                // Top row strobes first; its valid bit drops
                                // in the same cycle as its strobe.
                                r_row_inv   <= w_onehot;
                                r_valid_map <= r_valid_map & ~w_onehot;
                                r_state     <= ST_SWEEP;
                            end
                            default: begin
                                // Reserved opcode: complete immediately, flag it.
                                r_done  <= 1'b1;
                                r_err   <= 1'b1;
                                r_state <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == '0) begin
                        r_row_we  <= '0;
                        r_row_inv <= '0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                        if (r_op == OP_WRITE)
                            r_valid_map <= r_valid_map | w_onehot;
                        else
                            r_valid_map <= r_valid_map & ~w_onehot;
                    end else begin
                        r_cnt <= r_cnt - WR_CNT_W'(1);
                    end
                end
                ST_SWEEP: begin
                    if (r_idx == '0) begin
                        r_row_inv <= '0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_idx       <= w_dec_idx;
                        r_row_inv   <= w_onehot;
                        r_valid_map <= r_valid_map & ~w_onehot;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
